// File: rtl/csr_mregs_pkg.sv
// Shared CSR addresses, bit positions and helpers for the machine-mode CSR bank.
package csr_mregs_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int IRQ_SW_BIT       = 3;
  localparam int IRQ_TIMER_BIT    = 7;
  localparam int IRQ_EXT_BIT      = 11;

  localparam logic [31:0] MTVEC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] MISA_DEFAULT        = 32'h4000_0100;

  // Packs the three interrupt lines into their mie/mip bit positions.
  function automatic logic [31:0] irq_word(input logic ext, input logic tim, input logic sw);
    logic [31:0] w;
    w = 32'h0;
    w[IRQ_EXT_BIT]   = ext;
    w[IRQ_TIMER_BIT] = tim;
    w[IRQ_SW_BIT]    = sw;
    return w;
  endfunction

  function automatic logic [31:0] mstatus_word(input logic mie, input logic mpie);
    logic [31:0] w;
    w = 32'h0;
    w[MSTATUS_MIE_BIT]  = mie;
    w[MSTATUS_MPIE_BIT] = mpie;
    return w;
  endfunction

endpackage

// File: rtl/csr_mregs_counter64.sv
// 64-bit free-running counter with independent half loads; a load suppresses the increment.
module csr_mregs_counter64 (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt_q <= 64'h0;
    end else if (we_lo_i || we_hi_i) begin
      // Loading one half leaves the other untouched: no increment, no carry.
      if (we_lo_i) cnt_q[31:0]  <= wdata_i;
      if (we_hi_i) cnt_q[63:32] <= wdata_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/csr_mregs.sv
// Machine-mode CSR bank: trap state, interrupt enable/pending, vectors and mcycle/minstret.
module csr_mregs
  import csr_mregs_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = MTVEC_RESET_DEFAULT,
  parameter logic [31:0] MHARTID     = 32'h0,
  parameter logic [31:0] MISA_VAL    = MISA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        instret_i,
  input  logic        irq_external_i,
  input  logic        irq_timer_i,
  input  logic        irq_sw_i,
  input  logic        ie_type_i,
  input  logic        set_cause_i,
  input  logic [3:0]  trap_cause_i,
  input  logic        set_epc_i,
  input  logic [31:0] epc_i,
  input  logic        set_mtval_i,
  input  logic [31:0] mtval_i,
  input  logic        mstatus_ie_clear_i,
  input  logic        mstatus_ie_set_i,
  output logic        mstatus_ie_o,
  output logic        mie_external_o,
  output logic        mie_timer_o,
  output logic        mie_sw_o,
  output logic        mip_external_o,
  output logic        mip_timer_o,
  output logic        mip_sw_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] epc_o
);

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic        mie_ext_q, mie_tim_q, mie_sw_q;
  logic        mip_ext_q, mip_tim_q, mip_sw_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mtval_q;
  logic        mcause_int_q;
  logic [3:0]  mcause_code_q;
  logic [63:0] mcycle, minstret;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
  logic load_mtval;

  assign wr_mstatus   = we_i && (waddr_i == CSR_MSTATUS);
  assign wr_mie       = we_i && (waddr_i == CSR_MIE);
  assign wr_mtvec     = we_i && (waddr_i == CSR_MTVEC);
  assign wr_mscratch  = we_i && (waddr_i == CSR_MSCRATCH);
  assign wr_mepc      = we_i && (waddr_i == CSR_MEPC);
  assign wr_mcause    = we_i && (waddr_i == CSR_MCAUSE);
  assign wr_mtval     = we_i && (waddr_i == CSR_MTVAL);
  assign wr_mcycle    = we_i && (waddr_i == CSR_MCYCLE);
  assign wr_mcycleh   = we_i && (waddr_i == CSR_MCYCLEH);
  assign wr_minstret  = we_i && (waddr_i == CSR_MINSTRET);
  assign wr_minstreth = we_i && (waddr_i == CSR_MINSTRETH);

  // mtval only follows the trap controller when a cause is being recorded too.
  assign load_mtval = set_mtval_i && set_cause_i;

  // Hardware strobes win over a software write to the same CSR; clear wins over set.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (mstatus_ie_clear_i) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mstatus_ie_set_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr_mstatus) begin
      mstatus_mie_q  <= wdata_i[MSTATUS_MIE_BIT];
      mstatus_mpie_q <= wdata_i[MSTATUS_MPIE_BIT];
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mie_ext_q <= 1'b0;
      mie_tim_q <= 1'b0;
      mie_sw_q  <= 1'b0;
    end else if (wr_mie) begin
      mie_ext_q <= wdata_i[IRQ_EXT_BIT];
      mie_tim_q <= wdata_i[IRQ_TIMER_BIT];
      mie_sw_q  <= wdata_i[IRQ_SW_BIT];
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mip_ext_q <= 1'b0;
      mip_tim_q <= 1'b0;
      mip_sw_q  <= 1'b0;
    end else begin
      mip_ext_q <= irq_external_i;
      mip_tim_q <= irq_timer_i;
      mip_sw_q  <= irq_sw_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
    end else begin
      if (wr_mtvec)    mtvec_q    <= {wdata_i[31:2], 1'b0, wdata_i[0]};
      if (wr_mscratch) mscratch_q <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mepc_q <= 32'h0;
    end else if (set_epc_i) begin
      mepc_q <= {epc_i[31:2], 2'b00};
    end else if (wr_mepc) begin
      mepc_q <= {wdata_i[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mcause_int_q  <= 1'b0;
      mcause_code_q <= 4'h0;
    end else if (set_cause_i) begin
      mcause_int_q  <= ie_type_i;
      mcause_code_q <= trap_cause_i;
    end else if (wr_mcause) begin
      mcause_int_q  <= wdata_i[31];
      mcause_code_q <= wdata_i[3:0];
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mtval_q <= 32'h0;
    end else if (load_mtval) begin
      mtval_q <= mtval_i;
    end else if (wr_mtval) begin
      mtval_q <= wdata_i;
    end
  end

  csr_mregs_counter64 u_mcycle (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .inc_i   (1'b1),
    .we_lo_i (wr_mcycle),
    .we_hi_i (wr_mcycleh),
    .wdata_i (wdata_i),
    .value_o (mcycle)
  );

  csr_mregs_counter64 u_minstret (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .inc_i   (instret_i),
    .we_lo_i (wr_minstret),
    .we_hi_i (wr_minstreth),
    .wdata_i (wdata_i),
    .value_o (minstret)
  );

  // Read port sees registered state only; a same-cycle write shows up next cycle.
  always_comb begin
    rdata_o = 32'h0;
    case (raddr_i)
      CSR_MSTATUS:                rdata_o = mstatus_word(mstatus_mie_q, mstatus_mpie_q);
      CSR_MISA:                   rdata_o = MISA_VAL;
      CSR_MIE:                    rdata_o = irq_word(mie_ext_q, mie_tim_q, mie_sw_q);
      CSR_MTVEC:                  rdata_o = mtvec_q;
      CSR_MSCRATCH:               rdata_o = mscratch_q;
      CSR_MEPC:                   rdata_o = mepc_q;
      CSR_MCAUSE:                 rdata_o = {mcause_int_q, 27'h0, mcause_code_q};
      CSR_MTVAL:                  rdata_o = mtval_q;
      CSR_MIP:                    rdata_o = irq_word(mip_ext_q, mip_tim_q, mip_sw_q);
      CSR_MCYCLE,   CSR_CYCLE:    rdata_o = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rdata_o = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rdata_o = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_o = minstret[63:32];
      CSR_MHARTID:                rdata_o = MHARTID;
      default:                    rdata_o = 32'h0;
    endcase
  end

  assign mstatus_ie_o   = mstatus_mie_q;
  assign mie_external_o = mie_ext_q;
  assign mie_timer_o    = mie_tim_q;
  assign mie_sw_o       = mie_sw_q;
  assign mip_external_o = mip_ext_q;
  assign mip_timer_o    = mip_tim_q;
  assign mip_sw_o       = mip_sw_q;
  assign mtvec_o        = mtvec_q;
  assign epc_o          = mepc_q;

endmodule

// File: tb/tb_csr_mregs.sv
// Directed bench for csr_mregs: drivers push expectations, a monitor pops and compares.
module tb_csr_mregs;

  localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0100;
  localparam logic [31:0] TB_MHARTID     = 32'h0000_0003;
  localparam logic [31:0] TB_MISA        = 32'h4000_0100;

  localparam int SEL_RDATA = 0;
  localparam int SEL_MTVEC = 1;
  localparam int SEL_EPC   = 2;
  localparam int SEL_MIE_S = 3;
  localparam int SEL_MIE   = 4;
  localparam int SEL_MIP   = 5;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic [11:0] raddr_i = 12'h0;
  logic [31:0] rdata_o;
  logic        we_i = 1'b0;
  logic [11:0] waddr_i = 12'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        instret_i = 1'b0;
  logic        irq_external_i = 1'b0;
  logic        irq_timer_i = 1'b0;
  logic        irq_sw_i = 1'b0;
  logic        ie_type_i = 1'b0;
  logic        set_cause_i = 1'b0;
  logic [3:0]  trap_cause_i = 4'h0;
  logic        set_epc_i = 1'b0;
  logic [31:0] epc_i = 32'h0;
  logic        set_mtval_i = 1'b0;
  logic [31:0] mtval_i = 32'h0;
  logic        mstatus_ie_clear_i = 1'b0;
  logic        mstatus_ie_set_i = 1'b0;
  logic        mstatus_ie_o;
  logic        mie_external_o, mie_timer_o, mie_sw_o;
  logic        mip_external_o, mip_timer_o, mip_sw_o;
  logic [31:0] mtvec_o;
  logic [31:0] epc_o;

  csr_mregs #(
    .MTVEC_RESET (TB_MTVEC_RESET),
    .MHARTID     (TB_MHARTID),
    .MISA_VAL    (TB_MISA)
  ) dut (
    .clk_i              (clk_i),
    .n_rst_i            (n_rst_i),
    .raddr_i            (raddr_i),
    .rdata_o            (rdata_o),
    .we_i               (we_i),
    .waddr_i            (waddr_i),
    .wdata_i            (wdata_i),
    .instret_i          (instret_i),
    .irq_external_i     (irq_external_i),
    .irq_timer_i        (irq_timer_i),
    .irq_sw_i           (irq_sw_i),
    .ie_type_i          (ie_type_i),
    .set_cause_i        (set_cause_i),
    .trap_cause_i       (trap_cause_i),
    .set_epc_i          (set_epc_i),
    .epc_i              (epc_i),
    .set_mtval_i        (set_mtval_i),
    .mtval_i            (mtval_i),
    .mstatus_ie_clear_i (mstatus_ie_clear_i),
    .mstatus_ie_set_i   (mstatus_ie_set_i),
    .mstatus_ie_o       (mstatus_ie_o),
    .mie_external_o     (mie_external_o),
    .mie_timer_o        (mie_timer_o),
    .mie_sw_o           (mie_sw_o),
    .mip_external_o     (mip_external_o),
    .mip_timer_o        (mip_timer_o),
    .mip_sw_o           (mip_sw_o),
    .mtvec_o            (mtvec_o),
    .epc_o              (epc_o)
  );

  // Clock/reset: long period so several #1-spaced checks fit between edges.
  always #50 clk_i = ~clk_i;

  // Scoreboard
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad = 0;
  event        chk_ev;

  function automatic logic [31:0] observe(input int s);
    case (s)
      SEL_RDATA: return rdata_o;
      SEL_MTVEC: return mtvec_o;
      SEL_EPC:   return epc_o;
      SEL_MIE_S: return {31'h0, mstatus_ie_o};
      SEL_MIE:   return {29'h0, mie_external_o, mie_timer_o, mie_sw_o};
      SEL_MIP:   return {29'h0, mip_external_o, mip_timer_o, mip_sw_o};
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  always @(chk_ev) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] a;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = observe(s);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %08h want %08h", n, a, e);
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_sel(input int s, input logic [31:0] e, input string n);
    sel_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(n);
    -> chk_ev;
    #1;
  endtask

  task automatic check_rd(input logic [11:0] a, input logic [31:0] e, input string n);
    raddr_i = a;
    #1;
    expect_sel(SEL_RDATA, e, n);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    we_i = 1'b1;
    waddr_i = a;
    wdata_i = d;
    cyc();
    we_i = 1'b0;
  endtask

  initial begin
    // 1: reset
    repeat (3) cyc();
    expect_sel(SEL_MTVEC, TB_MTVEC_RESET, "rst_hold_mtvec");
    expect_sel(SEL_MIE_S, 32'h0, "rst_hold_mie");
    n_rst_i = 1'b1;
    cyc();
    expect_sel(SEL_MTVEC, TB_MTVEC_RESET, "rst_mtvec");
    expect_sel(SEL_EPC, 32'h0, "rst_epc");
    expect_sel(SEL_MIE_S, 32'h0, "rst_mstatus_ie");
    expect_sel(SEL_MIE, 32'h0, "rst_mie");
    expect_sel(SEL_MIP, 32'h0, "rst_mip");
    check_rd(12'hF14, TB_MHARTID, "rst_mhartid");
    check_rd(12'h301, TB_MISA, "rst_misa");
    check_rd(12'h300, 32'h0, "rst_mstatus");
    check_rd(12'h342, 32'h0, "rst_mcause");
    check_rd(12'h343, 32'h0, "rst_mtval");
    check_rd(12'h340, 32'h0, "rst_mscratch");
    check_rd(12'hB02, 32'h0, "rst_minstret");

    // 2: enables, pending, trap entry
    csr_wr(12'h300, 32'hFFFF_FF08);
    check_rd(12'h300, 32'h0000_0008, "mstatus_wr");
    expect_sel(SEL_MIE_S, 32'h1, "mstatus_ie_set");
    csr_wr(12'h304, 32'hFFFF_F800);
    check_rd(12'h304, 32'h0000_0800, "mie_wr");
    expect_sel(SEL_MIE, 32'h4, "mie_ext_out");
    irq_external_i = 1'b1;
    expect_sel(SEL_MIP, 32'h0, "mip_before_edge");
    cyc();
    expect_sel(SEL_MIP, 32'h4, "mip_ext_out");
    check_rd(12'h344, 32'h0000_0800, "mip_rd");
    csr_wr(12'h344, 32'h0);
    expect_sel(SEL_MIP, 32'h4, "mip_wr_ignored");
    set_cause_i = 1'b1; set_epc_i = 1'b1; mstatus_ie_clear_i = 1'b1;
    trap_cause_i = 4'hB; ie_type_i = 1'b1; epc_i = 32'h104;
    csr_wr(12'h342, 32'h0000_0005);
    set_cause_i = 1'b0; set_epc_i = 1'b0; mstatus_ie_clear_i = 1'b0;
    check_rd(12'h342, 32'h8000_000B, "trap_mcause");
    expect_sel(SEL_EPC, 32'h104, "trap_epc");
    expect_sel(SEL_MIE_S, 32'h0, "trap_mie");
    check_rd(12'h300, 32'h0000_0080, "trap_mstatus");

    // 3: mret, clear+set together, strobe vs write
    mstatus_ie_set_i = 1'b1;
    cyc();
    mstatus_ie_set_i = 1'b0;
    check_rd(12'h300, 32'h0000_0088, "mret_mstatus");
    expect_sel(SEL_MIE_S, 32'h1, "mret_mie");
    mstatus_ie_set_i = 1'b1; mstatus_ie_clear_i = 1'b1;
    cyc();
    mstatus_ie_set_i = 1'b0; mstatus_ie_clear_i = 1'b0;
    check_rd(12'h300, 32'h0000_0080, "clear_wins");
    mstatus_ie_set_i = 1'b1;
    csr_wr(12'h300, 32'h0);
    mstatus_ie_set_i = 1'b0;
    check_rd(12'h300, 32'h0000_0088, "strobe_over_wr");

    // 4: mepc priority and alignment, mtval, mcause, mscratch
    set_epc_i = 1'b1; epc_i = 32'h300;
    csr_wr(12'h341, 32'h200);
    set_epc_i = 1'b0;
    expect_sel(SEL_EPC, 32'h300, "epc_hw_wins");
    csr_wr(12'h341, 32'h207);
    check_rd(12'h341, 32'h204, "mepc_align");
    expect_sel(SEL_EPC, 32'h204, "epc_out_align");
    set_mtval_i = 1'b1; mtval_i = 32'h1234;
    cyc();
    check_rd(12'h343, 32'h0, "mtval_unqualified");
    set_cause_i = 1'b1; trap_cause_i = 4'h2; ie_type_i = 1'b0; mtval_i = 32'hCAFE;
    cyc();
    set_mtval_i = 1'b0; set_cause_i = 1'b0;
    check_rd(12'h343, 32'h0000_CAFE, "mtval_load");
    check_rd(12'h342, 32'h0000_0002, "mcause_exc");
    csr_wr(12'h342, 32'hFFFF_FFF5);
    check_rd(12'h342, 32'h8000_0005, "mcause_sw");
    csr_wr(12'h340, 32'h1234_5678);
    check_rd(12'h340, 32'h1234_5678, "mscratch");

    // 5: counters
    csr_wr(12'hB00, 32'hFFFF_FFFE);
    csr_wr(12'hB80, 32'hFFFF_FFFF);
    check_rd(12'hB00, 32'hFFFF_FFFE, "mcycle_lo_hold");
    check_rd(12'hB80, 32'hFFFF_FFFF, "mcycle_hi");
    check_rd(12'hC80, 32'hFFFF_FFFF, "cycleh_alias");
    cyc();
    check_rd(12'hC00, 32'hFFFF_FFFF, "mcycle_max");
    cyc();
    check_rd(12'hB00, 32'h0, "mcycle_wrap_lo");
    check_rd(12'hB80, 32'h0, "mcycle_wrap_hi");
    cyc();
    check_rd(12'hB00, 32'h1, "mcycle_after_wrap");
    csr_wr(12'hB02, 32'h10);
    check_rd(12'hB02, 32'h10, "minstret_wr");
    instret_i = 1'b1;
    repeat (3) cyc();
    instret_i = 1'b0;
    check_rd(12'hC02, 32'h13, "minstret_inc");
    repeat (2) cyc();
    check_rd(12'hB02, 32'h13, "minstret_idle");
    instret_i = 1'b1;
    csr_wr(12'hB02, 32'h50);
    instret_i = 1'b0;
    check_rd(12'hB02, 32'h50, "minstret_wr_skip_inc");
    csr_wr(12'hB02, 32'hFFFF_FFFF);
    instret_i = 1'b1;
    cyc();
    instret_i = 1'b0;
    check_rd(12'hB02, 32'h0, "minstret_carry_lo");
    check_rd(12'hB82, 32'h1, "minstret_carry_hi");

    // 6: unimplemented / read-only addresses, mtvec mode
    csr_wr(12'h7C0, 32'hDEAD_BEEF);
    check_rd(12'h7C0, 32'h0, "unimpl_rd");
    check_rd(12'h340, 32'h1234_5678, "unimpl_no_effect");
    csr_wr(12'hC02, 32'h77);
    csr_wr(12'hC82, 32'h77);
    check_rd(12'hB02, 32'h0, "ro_alias_lo");
    check_rd(12'hB82, 32'h1, "ro_alias_hi");
    csr_wr(12'h305, 32'h8000_0003);
    check_rd(12'h305, 32'h8000_0001, "mtvec_mode");
    expect_sel(SEL_MTVEC, 32'h8000_0001, "mtvec_out");

    // Reset mid-write aborts it
    we_i = 1'b1; waddr_i = 12'h305; wdata_i = 32'hAAAA_AAA8;
    #5;
    n_rst_i = 1'b0;
    #1;
    expect_sel(SEL_MTVEC, TB_MTVEC_RESET, "async_rst_mtvec");
    expect_sel(SEL_EPC, 32'h0, "async_rst_epc");
    cyc();
    we_i = 1'b0;
    n_rst_i = 1'b1;
    irq_external_i = 1'b0;
    cyc();
    expect_sel(SEL_MTVEC, TB_MTVEC_RESET, "rst_abort_write");
    check_rd(12'h340, 32'h0, "rst_mscratch_again");

    @(negedge clk_i);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
